// File: rtl/bank_sched_pkg.sv
// bank_sched_pkg: shared types for the bank scheduler.
// Shadow sense-cycle state encoding and requester port ids.
package bank_sched_pkg;

  typedef enum logic [3:0] {
    SH_PRE = 4'b0001,
    SH_WR  = 4'b0010,
    SH_S1  = 4'b0100,
    SH_S2  = 4'b1000
  } shadow_e;

  localparam logic HOST = 1'b0;
  localparam logic COMP = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/bank_sched_track.sv
// bank_track: per-bank shadow of the controller sequence plus the
// w_en/row registers. Ports: rd_acc/wr_acc/acc_port/acc_row in; w_en, row, rd_elig, wr_elig, rd_fire, rd_owner out.
module bank_track
  import bank_sched_pkg::*;
#(
  parameter int ROW_W     = 6,
  parameter int WR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_acc,
  input  logic             wr_acc,
  input  logic             acc_port,
  input  logic [ROW_W-1:0] acc_row,
  output logic             w_en,
  output logic [ROW_W-1:0] row,
  output logic             rd_elig,
  output logic             wr_elig,
  output logic             rd_fire,
  output logic             rd_owner
);

  // cnt==0 marks the last w_en cycle, so a
  // follow-on write can keep w_en continuous.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(WR_CYCLES - 1);

  shadow_e          st, st_nx;
  logic [CNT_W-1:0] cnt;
  logic             pend;

  always_comb begin
    st_nx = st;
    unique case (st)
      SH_PRE:  st_nx = w_en ? SH_WR : SH_S1;
      SH_WR:   st_nx = w_en ? SH_WR : SH_PRE;
      SH_S1:   st_nx = SH_S2;
      SH_S2:   st_nx = w_en ? SH_WR : SH_PRE;
      default: st_nx = SH_PRE;
    endcase
  end

  assign wr_elig = (cnt == '0) & ~pend;
  assign rd_elig = (st == SH_PRE) & ~w_en & wr_elig;
  assign rd_fire = (st == SH_S2) & pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= SH_PRE;
      cnt      <= '0;
      pend     <= 1'b0;
      rd_owner <= HOST;
      w_en     <= 1'b0;
      row      <= '0;
    end else begin
      st <= st_nx;
      if (wr_acc) begin
        w_en <= 1'b1;
        cnt  <= CNT_LOAD;
      end else begin
        w_en <= (cnt != '0);
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (rd_acc | wr_acc) row <= acc_row;
      if (rd_acc) begin
        pend     <= 1'b1;
        rd_owner <= acc_port;
      end else if (rd_fire) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bank_sched.sv
// bank_sched: arbitrates host/compute requests onto banks, drives w_en/row, flags rd_valid/rd_bank.
// Option BANK_SCHED_HOST_PRIO_EN: host wins same-bank ties.
module bank_sched
  import bank_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 6,
  parameter int WR_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [1:0]                        req_we,
  input  logic [2*$clog2(NUM_BANKS)-1:0]    req_bank,
  input  logic [2*ROW_W-1:0]                req_row,
  output logic [NUM_BANKS-1:0]              bank_w_en,
  output logic [NUM_BANKS*ROW_W-1:0]        bank_row,
  output logic [1:0]                        rd_valid,
  output logic [2*$clog2(NUM_BANKS)-1:0]    rd_bank
);

  localparam int BW = $clog2(NUM_BANKS);

  logic [BW-1:0]        bank0, bank1;
  logic [ROW_W-1:0]     row0, row1;
  logic [NUM_BANKS-1:0] rd_elig, wr_elig;
  logic [NUM_BANKS-1:0] rd_fire, rd_owner;
  logic                 elig0, elig1, same;
  logic                 winner, xfer0, xfer1;

  assign bank0 = req_bank[BW-1:0];
  assign bank1 = req_bank[2*BW-1:BW];
  assign row0  = req_row[ROW_W-1:0];
  assign row1  = req_row[2*ROW_W-1:ROW_W];

  assign elig0 = req_we[0] ? wr_elig[bank0]
                           : rd_elig[bank0];
  assign elig1 = req_we[1] ? wr_elig[bank1]
                           : rd_elig[bank1];
  assign same  = (bank0 == bank1);

`ifdef BANK_SCHED_HOST_PRIO_EN
  assign winner = HOST;
`else
  logic ptr, contend;
  assign winner  = ptr;
  assign contend = same & (&req_valid)
                 & elig0 & elig1;

  // Hand the next tie to this tie's loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= HOST;
    else if (contend) ptr <= ~ptr;
  end
`endif

  // A port is held off only by a valid, eligible
  // rival on its bank that holds the tie.
  assign req_ready[0] = elig0 & ~(same
    & req_valid[1] & elig1 & (winner == COMP));
  assign req_ready[1] = elig1 & ~(same
    & req_valid[0] & elig0 & (winner == HOST));

  assign xfer0 = req_valid[0] & req_ready[0];
  assign xfer1 = req_valid[1] & req_ready[1];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic hit0, hit1, rd_acc, wr_acc;
    assign hit0 = xfer0 & (bank0 == BW'(b));
    assign hit1 = xfer1 & (bank1 == BW'(b));
    assign rd_acc = (hit0 & ~req_we[0])
                  | (hit1 & ~req_we[1]);
    assign wr_acc = (hit0 & req_we[0])
                  | (hit1 & req_we[1]);

    bank_track #(
      .ROW_W     (ROW_W),
      .WR_CYCLES (WR_CYCLES)
    ) u_track (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_acc   (rd_acc),
      .wr_acc   (wr_acc),
      .acc_port (hit1 ? COMP : HOST),
      .acc_row  (hit1 ? row1 : row0),
      .w_en     (bank_w_en[b]),
      .row      (bank_row[b*ROW_W +: ROW_W]),
      .rd_elig  (rd_elig[b]),
      .wr_elig  (wr_elig[b]),
      .rd_fire  (rd_fire[b]),
      .rd_owner (rd_owner[b])
    );
  end

  // Fixed read latency means a port has at most
  // one bank firing for it in any cycle.
  always_comb begin
    rd_valid = '0;
    rd_bank  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_fire[b]) begin
        rd_valid[rd_owner[b]] = 1'b1;
        if (rd_owner[b]) rd_bank[2*BW-1:BW] = BW'(b);
        else             rd_bank[BW-1:0]    = BW'(b);
      end
    end
  end

endmodule
